// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and byte-lane helpers for the data-memory access unit.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RSP     = 2'd2
  } dmemState_t;

  // Byte-enable mask of a naturally aligned access within one 32-bit word.
  function automatic logic [3:0] byteEnMask(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] mask;
    case (size)
      SZ_BYTE: mask = 4'b0001 << offset;
      SZ_HALF: mask = 4'b0011 << offset;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic isAccessError(input logic [1:0] size, input logic [1:0] offset);
    return ((size == SZ_HALF) && offset[0]) ||
           ((size == SZ_WORD) && (offset != 2'b00)) ||
           (size == 2'b11);
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Combinational lane select and sign/zero extension of a BRAM read word.
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int COL_WIDTH  = 8,
  parameter int NUM_COL    = 4,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] memDout,
  input  logic [1:0]            offset,
  input  logic [1:0]            size,
  input  logic                  isUnsigned,
  output logic [DATA_WIDTH-1:0] result
);

  logic [COL_WIDTH-1:0]   lanes [NUM_COL];
  logic [COL_WIDTH-1:0]   byteSel;
  logic [2*COL_WIDTH-1:0] halfSel;

  generate
    for (genvar gi = 0; gi < NUM_COL; gi++) begin : g_lane
      assign lanes[gi] = memDout[gi*COL_WIDTH +: COL_WIDTH];
    end
  endgenerate

  always_comb begin
    byteSel = lanes[offset];
    halfSel = offset[1] ? memDout[DATA_WIDTH-1 -: 2*COL_WIDTH] : memDout[2*COL_WIDTH-1:0];
    result  = '0;
    case (size)
      SZ_BYTE: result = {{(DATA_WIDTH-COL_WIDTH){~isUnsigned & byteSel[COL_WIDTH-1]}}, byteSel};
      SZ_HALF: result = {{(DATA_WIDTH-2*COL_WIDTH){~isUnsigned & halfSel[2*COL_WIDTH-1]}}, halfSel};
      SZ_WORD: result = memDout;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Core-side load/store port onto one byte-write BRAM port (no-change mode, 1-cycle read),
// returning aligned load data or an error flag on a valid/ready response channel.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [1:0]              req_size,
  input  logic                    req_unsigned,
  input  logic [ADDR_WIDTH+1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    mem_en,
  output logic [NUM_COL-1:0]      mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  input  logic [DATA_WIDTH-1:0]   mem_dout
);

  dmemState_t            stateReg, stateNext;
  logic [1:0]            offsetReg, offsetNext;
  logic [1:0]            sizeReg, sizeNext;
  logic                  unsignedReg, unsignedNext;
  logic                  rspValidReg, rspValidNext;
  logic                  rspErrReg, rspErrNext;
  logic [DATA_WIDTH-1:0] rspRdataReg, rspRdataNext;

  logic                  accept;
  logic                  accessErr;
  logic                  doAccess;
  logic                  doStore;
  logic [DATA_WIDTH-1:0] replData;
  logic [DATA_WIDTH-1:0] alignedData;

  assign req_ready = (stateReg == IDLE);
  assign accept    = req_valid & req_ready;
  assign accessErr = isAccessError(req_size, req_addr[1:0]);
  assign doAccess  = accept & ~accessErr;
  assign doStore   = doAccess & req_we;

  // Store data replicated across lanes so the byte enables alone pick the target bytes.
  generate
    for (genvar gi = 0; gi < NUM_COL; gi++) begin : g_repl
      assign replData[gi*COL_WIDTH +: COL_WIDTH] =
          (req_size == SZ_BYTE) ? req_wdata[COL_WIDTH-1:0] :
          (req_size == SZ_HALF) ? req_wdata[(gi%2)*COL_WIDTH +: COL_WIDTH] :
                                  req_wdata[gi*COL_WIDTH +: COL_WIDTH];
    end
  endgenerate

  assign mem_en   = doAccess;
  assign mem_we   = doStore ? byteEnMask(req_size, req_addr[1:0]) : '0;
  assign mem_addr = doAccess ? req_addr[ADDR_WIDTH+1:2] : '0;
  assign mem_din  = doStore ? replData : '0;

  dmem_load_align #(
    .COL_WIDTH (COL_WIDTH),
    .NUM_COL   (NUM_COL),
    .DATA_WIDTH(DATA_WIDTH)
  ) uLoadAlign (
    .memDout   (mem_dout),
    .offset    (offsetReg),
    .size      (sizeReg),
    .isUnsigned(unsignedReg),
    .result    (alignedData)
  );

  always_comb begin
    stateNext    = stateReg;
    offsetNext   = offsetReg;
    sizeNext     = sizeReg;
    unsignedNext = unsignedReg;
    rspValidNext = rspValidReg;
    rspErrNext   = rspErrReg;
    rspRdataNext = rspRdataReg;
    case (stateReg)
      IDLE: begin
        if (accept) begin
          if (accessErr || req_we) begin
            stateNext    = RSP;
            rspValidNext = 1'b1;
            rspErrNext   = accessErr;
            rspRdataNext = '0;
          end else begin
            stateNext    = RD_WAIT;
            offsetNext   = req_addr[1:0];
            sizeNext     = req_size;
            unsignedNext = req_unsigned;
          end
        end
      end
      // mem_dout is only trusted in this cycle; no-change mode holds it otherwise.
      RD_WAIT: begin
        stateNext    = RSP;
        rspValidNext = 1'b1;
        rspErrNext   = 1'b0;
        rspRdataNext = alignedData;
      end
      RSP: begin
        if (rsp_ready) begin
          stateNext    = IDLE;
          rspValidNext = 1'b0;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg    <= IDLE;
      offsetReg   <= '0;
      sizeReg     <= '0;
      unsignedReg <= 1'b0;
      rspValidReg <= 1'b0;
      rspErrReg   <= 1'b0;
      rspRdataReg <= '0;
    end else begin
      stateReg    <= stateNext;
      offsetReg   <= offsetNext;
      sizeReg     <= sizeNext;
      unsignedReg <= unsignedNext;
      rspValidReg <= rspValidNext;
      rspErrReg   <= rspErrNext;
      rspRdataReg <= rspRdataNext;
    end
  end

  assign rsp_valid = rspValidReg;
  assign rsp_err   = rspErrReg;
  assign rsp_rdata = rspRdataReg;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit driving a behavioural byte-write BRAM (no-change, 1-cycle read).
module tb_dmem_access_unit;

  localparam int ADDR_WIDTH = 10;
  localparam int NUM_COL    = 4;
  localparam int COL_WIDTH  = 8;
  localparam int DATA_WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  logic                  req_we = 1'b0;
  logic [1:0]            req_size = 2'b00;
  logic                  req_unsigned = 1'b0;
  logic [ADDR_WIDTH+1:0] req_addr = '0;
  logic [DATA_WIDTH-1:0] req_wdata = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  mem_en;
  logic [NUM_COL-1:0]    mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [DATA_WIDTH-1:0] mem_dout = '0;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  dmem_access_unit #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_COL   (NUM_COL),
    .COL_WIDTH (COL_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout)
  );

  // Behavioural BRAM port: byte writes, read data 1 cycle later, output held during writes.
  logic [DATA_WIDTH-1:0] bram [1 << ADDR_WIDTH];
  initial begin
    for (int i = 0; i < (1 << ADDR_WIDTH); i++) bram[i] = '0;
  end
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we != '0) begin
        for (int c = 0; c < NUM_COL; c++)
          if (mem_we[c]) bram[mem_addr][c*COL_WIDTH +: COL_WIDTH] <= mem_din[c*COL_WIDTH +: COL_WIDTH];
      end else begin
        mem_dout <= bram[mem_addr];
      end
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // One transaction: checks the accept-cycle BRAM signals, response latency and payload,
  // an optional backpressure hold, then the return to IDLE.
  task automatic doReq(input string tag, input logic we, input logic [1:0] size, input logic uns,
                       input logic [11:0] addr, input logic [31:0] wdata,
                       input logic [3:0] expWe, input logic [31:0] expDin,
                       input logic [31:0] expRdata, input logic expErr, input int hold);
    int lat;
    int expLat;
    logic [9:0] expAddr;
    expLat  = (expErr || we) ? 1 : 2;
    expAddr = expErr ? 10'd0 : addr[11:2];
    @(negedge clk);
    checkVal({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    rsp_ready = (hold == 0);
    #1;
    checkVal({tag, ".mem_en"}, 32'(mem_en), 32'(!expErr));
    checkVal({tag, ".mem_we"}, 32'(mem_we), 32'(expWe));
    checkVal({tag, ".mem_addr"}, 32'(mem_addr), 32'(expAddr));
    if (we) checkVal({tag, ".mem_din"}, mem_din, expDin);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    checkVal({tag, ".latency"}, 32'(lat), 32'(expLat));
    checkVal({tag, ".rdata"}, rsp_rdata, expRdata);
    checkVal({tag, ".err"}, 32'(rsp_err), 32'(expErr));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkVal({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      checkVal({tag, ".hold_rdata"}, rsp_rdata, expRdata);
      checkVal({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkVal({tag, ".rsp_cleared"}, 32'(rsp_valid), 32'd0);
    checkVal({tag, ".back_idle"}, 32'(req_ready), 32'd1);
    $display("txn %-14s we=%0d size=%0d uns=%0d addr=0x%03h wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d",
             tag, we, size, uns, addr, wdata, rsp_rdata, rsp_err, lat);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkVal("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    checkVal("reset.rsp_rdata", rsp_rdata, 32'd0);
    checkVal("reset.rsp_err", 32'(rsp_err), 32'd0);
    checkVal("reset.req_ready", 32'(req_ready), 32'd1);
    checkVal("reset.mem_en", 32'(mem_en), 32'd0);

    //      tag          we    size   uns   addr      wdata          expWe    expDin         expRdata       err   hold
    doReq("sw_0x010",   1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'h00000000, 1'b0, 0);
    doReq("sb_0x013",   1'b1, 2'b00, 1'b0, 12'h013, 32'h000000A5, 4'b1000, 32'hA5A5A5A5, 32'h00000000, 1'b0, 0);
    doReq("lw_0x010",   1'b0, 2'b10, 1'b0, 12'h010, 32'h0,        4'b0000, 32'h0,        32'hA5ADBEEF, 1'b0, 0);
    doReq("lb_0x013",   1'b0, 2'b00, 1'b0, 12'h013, 32'h0,        4'b0000, 32'h0,        32'hFFFFFFA5, 1'b0, 0);
    doReq("lbu_0x013",  1'b0, 2'b00, 1'b1, 12'h013, 32'h0,        4'b0000, 32'h0,        32'h000000A5, 1'b0, 0);
    doReq("lh_0x010",   1'b0, 2'b01, 1'b0, 12'h010, 32'h0,        4'b0000, 32'h0,        32'hFFFFBEEF, 1'b0, 0);
    doReq("lhu_0x012",  1'b0, 2'b01, 1'b1, 12'h012, 32'h0,        4'b0000, 32'h0,        32'h0000A5AD, 1'b0, 0);
    doReq("lbu_0x011",  1'b0, 2'b00, 1'b1, 12'h011, 32'h0,        4'b0000, 32'h0,        32'h000000BE, 1'b0, 0);
    doReq("lh_0x011",   1'b0, 2'b01, 1'b0, 12'h011, 32'h0,        4'b0000, 32'h0,        32'h00000000, 1'b1, 0);
    doReq("lw_0x012",   1'b0, 2'b10, 1'b0, 12'h012, 32'h0,        4'b0000, 32'h0,        32'h00000000, 1'b1, 0);
    doReq("sw_0x011",   1'b1, 2'b10, 1'b0, 12'h011, 32'h11223344, 4'b0000, 32'h0,        32'h00000000, 1'b1, 0);
    doReq("s_size11",   1'b1, 2'b11, 1'b0, 12'h010, 32'h55667788, 4'b0000, 32'h0,        32'h00000000, 1'b1, 0);
    doReq("sh_0x016",   1'b1, 2'b01, 1'b0, 12'h016, 32'hFFFF1234, 4'b1100, 32'h12341234, 32'h00000000, 1'b0, 0);
    doReq("lw_0x014",   1'b0, 2'b10, 1'b0, 12'h014, 32'h0,        4'b0000, 32'h0,        32'h12340000, 1'b0, 0);
    doReq("lh_0x016",   1'b0, 2'b01, 1'b0, 12'h016, 32'h0,        4'b0000, 32'h0,        32'h00001234, 1'b0, 0);
    // Errors above must not have disturbed the stored word.
    doReq("lw_unchanged", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0,      4'b0000, 32'h0,        32'hA5ADBEEF, 1'b0, 0);
    doReq("lw_backpres", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0,       4'b0000, 32'h0,        32'hA5ADBEEF, 1'b0, 5);

    // Reset while a load waits on BRAM data: it must vanish without a response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 12'h010;
    @(negedge clk);
    req_valid = 1'b0;
    checkVal("rst_mid.in_rd_wait", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    checkVal("rst_mid.rsp_valid", 32'(rsp_valid), 32'd0);
    checkVal("rst_mid.req_ready", 32'(req_ready), 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkVal("rst_mid.no_rsp", 32'(rsp_valid), 32'd0);
    end
    $display("txn rst_mid        load discarded by reset, rsp_valid=%0d", rsp_valid);
    doReq("lw_after_rst", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0,      4'b0000, 32'h0,        32'hA5ADBEEF, 1'b0, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d checks", passCount, checkCount);
    $fatal(1, "timeout");
  end

endmodule
